// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter.
// Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out
// MSB first, one bit per clock, with a qualifying valid strobe and a
// last-bit marker. A new word can be taken in the last-bit cycle so that
// consecutive frames leave no gap on the serial line.
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             accept;

  // State, shift register and bit counter; reset drops any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: load on accept, otherwise shift and count down.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    accept    = load_valid && load_ready;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
          shreg_nxt = din;
          cnt_nxt   = CW'(WIDTH - 1);
        end
      end
      SHIFT: begin
        if (cnt == '0) begin
          // Last bit on the wire: either chain the next word or go idle.
          if (accept) begin
            shreg_nxt = din;
            cnt_nxt   = CW'(WIDTH - 1);
          end else begin
            state_nxt = IDLE;
            shreg_nxt = '0;
            cnt_nxt   = '0;
          end
        end else begin
          shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
          cnt_nxt   = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        shreg_nxt = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decoded purely from registered state (no path from din/load_valid).
  always_comb begin
    load_ready = 1'b1;
    sout       = 1'b0;
    sout_valid = 1'b0;
    last       = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        load_ready = 1'b1;
      end
      SHIFT: begin
        sout       = shreg[WIDTH-1];
        sout_valid = 1'b1;
        busy       = 1'b1;
        last       = (cnt == '0);
        load_ready = (cnt == '0);
      end
      default: begin
        load_ready = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer: directed WIDTH=4 frames with hand-computed
// bit sequences, plus random traffic on WIDTH=2 and WIDTH=8 instances
// reconstructed by a SIPO model and compared against the accepted words.
module tb_piso_serializer;

  logic clk;
  logic reset;

  // WIDTH=4 instance
  logic [3:0] din4;
  logic       lv4, rdy4, so4, sv4, last4, busy4;
  // WIDTH=2 instance
  logic [1:0] din2;
  logic       lv2, rdy2, so2, sv2, last2, busy2;
  // WIDTH=8 instance
  logic [7:0] din8;
  logic       lv8, rdy8, so8, sv8, last8, busy8;

  int checks = 0;
  int errors = 0;

  piso_serializer #(.WIDTH(4)) u_w4 (
    .clk(clk), .reset(reset), .din(din4), .load_valid(lv4), .load_ready(rdy4),
    .sout(so4), .sout_valid(sv4), .last(last4), .busy(busy4)
  );
  piso_serializer #(.WIDTH(2)) u_w2 (
    .clk(clk), .reset(reset), .din(din2), .load_valid(lv2), .load_ready(rdy2),
    .sout(so2), .sout_valid(sv2), .last(last2), .busy(busy2)
  );
  piso_serializer #(.WIDTH(8)) u_w8 (
    .clk(clk), .reset(reset), .din(din8), .load_valid(lv8), .load_ready(rdy8),
    .sout(so8), .sout_valid(sv8), .last(last8), .busy(busy8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle4(input string tag);
    chk({tag, "_rdy"},  rdy4,  1);
    chk({tag, "_sv"},   sv4,   0);
    chk({tag, "_sout"}, so4,   0);
    chk({tag, "_last"}, last4, 0);
    chk({tag, "_busy"}, busy4, 0);
  endtask

  // Check one WIDTH=4 frame cycle k (0..3) carrying word w.
  task automatic chk_bit4(input string tag, input logic [3:0] w, input int k);
    chk({tag, "_sout"}, so4,   w[3-k]);
    chk({tag, "_sv"},   sv4,   1);
    chk({tag, "_busy"}, busy4, 1);
    chk({tag, "_last"}, last4, (k == 3));
    chk({tag, "_rdy"},  rdy4,  (k == 3));
  endtask

  // Bench-side SIPO for the WIDTH=4 instance.
  logic [3:0] sipo4 = '0;
  always @(negedge clk) if (sv4) sipo4 = {sipo4[2:0], so4};

  // Scoreboards for the random sweeps.
  logic [1:0] q2[$];
  logic [7:0] q8[$];
  logic [1:0] sipo2 = '0;
  logic [7:0] sipo8 = '0;
  int acc2 = 0, lasts2 = 0, acc8 = 0, lasts8 = 0;

  always @(negedge clk) begin
    if (reset && lv2 && rdy2) begin q2.push_back(din2); acc2++; end
    if (sv2) begin
      sipo2 = {sipo2[0], so2};
      if (last2) begin
        lasts2++;
        if (q2.size() == 0) chk("w2_underflow", 1, 0);
        else chk("w2_word", sipo2, q2.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (reset && lv8 && rdy8) begin q8.push_back(din8); acc8++; end
    if (sv8) begin
      sipo8 = {sipo8[6:0], so8};
      if (last8) begin
        lasts8++;
        if (q8.size() == 0) chk("w8_underflow", 1, 0);
        else chk("w8_word", sipo8, q8.pop_front());
      end
    end
  end

  logic [7:0] bb;

  initial begin
    reset = 1'b0;
    din4 = '0; lv4 = 0;
    din2 = '0; lv2 = 0;
    din8 = '0; lv8 = 0;

    // Reset values held over 3 cycles
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_idle4("rst");
      chk("rst_w8_rdy", rdy8, 1);
      chk("rst_w2_sv", sv2, 0);
      tick();
    end
    reset = 1'b1;
    tick();
    chk_idle4("post_rst");

    // Single frame 1011
    din4 = 4'b1011; lv4 = 1;
    tick();
    lv4 = 0; din4 = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      chk_bit4("single", 4'b1011, k);
      tick();
    end
    chk_idle4("single_end");
    chk("single_sipo", sipo4, 4'b1011);

    // Back-to-back 1100 then 0011
    bb = 8'b1100_0011;
    din4 = 4'b1100; lv4 = 1;
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("b2b_sout", so4, bb[7-k]);
      chk("b2b_sv", sv4, 1);
      chk("b2b_last", last4, (k == 3 || k == 7));
      if (k == 3) din4 = 4'b0011;
      tick();
      if (k == 3) lv4 = 0;
    end
    chk_idle4("b2b_end");
    chk("b2b_sipo", sipo4, 4'b0011);

    // Ignored load during cycle 2 of a 1000 frame
    din4 = 4'b1000; lv4 = 1;
    tick();
    lv4 = 0;
    for (int k = 0; k < 4; k++) begin
      chk_bit4("ign", 4'b1000, k);
      if (k == 1) begin din4 = 4'b1111; lv4 = 1; end
      tick();
      lv4 = 0;
    end
    chk_idle4("ign_end0");
    chk("ign_sipo", sipo4, 4'b1000);
    tick();
    chk_idle4("ign_end1");

    // Reset mid-frame in cycle 2 of a 1010 frame
    din4 = 4'b1010; lv4 = 1;
    tick();
    lv4 = 0;
    chk_bit4("rmf", 4'b1010, 0);
    tick();
    chk_bit4("rmf", 4'b1010, 1);
    #2 reset = 1'b0;
    #1;
    chk_idle4("rmf_async");
    tick();
    chk_idle4("rmf_held");
    reset = 1'b1;
    din4 = 4'b0110; lv4 = 1;
    tick();
    lv4 = 0;
    for (int k = 0; k < 4; k++) begin
      chk_bit4("after_rst", 4'b0110, k);
      tick();
    end
    chk_idle4("after_rst_end");
    chk("after_rst_sipo", sipo4, 4'b0110);

    // Random sweep on WIDTH=2 and WIDTH=8
    for (int i = 0; i < 400; i++) begin
      lv2  = ($urandom_range(0, 3) != 0);
      din2 = 2'($urandom);
      lv8  = ($urandom_range(0, 3) != 0);
      din8 = 8'($urandom);
      tick();
    end
    lv2 = 0; lv8 = 0;
    repeat (12) tick();
    chk("w2_frames", lasts2, acc2);
    chk("w2_drained", q2.size(), 0);
    chk("w2_idle", sv2, 0);
    chk("w8_frames", lasts8, acc8);
    chk("w8_drained", q8.size(), 0);
    chk("w8_idle", sv8, 0);
    chk("w2_some", (acc2 > 20), 1);
    chk("w8_some", (acc8 > 10), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
